bp_fe_instr_realigner: RTL and testbench

- Sits between the I$ fetch-packet output and the FE instruction scanner.
- Splits 32-bit fetch packets, each holding two 16-bit parcels, into whole RV64GC instructions. Instructions may be compressed, or 32-bit and straddling a packet boundary.
- Emits one instruction per cycle with its PC through a registered valid/ready-and output.
- Holds one leftover parcel across packets and flushes it on redirect.

---
 rtl/bp_fe_instr_realigner.sv | 113 +++++++++++
 tb/tb_bp_fe_instr_realigner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bp_fe_instr_realigner.sv
// bp_fe_instr_realigner: splits 2-parcel fetch packets into whole RV64GC instructions.
//   clk_i, reset_i (async, active-high)    clock and reset
//   redirect_i                             drop the residual parcel and the output register
//   fetch_v_i / fetch_ready_and_o          fetch packet handshake
//   fetch_pc_i, fetch_data_i               packet PC (bit1 = start at upper parcel) and parcels
//   instr_v_o / instr_ready_and_i          registered instruction handshake
//   instr_o, instr_pc_o, instr_compressed_o  instruction, its PC, 16-bit flag
module bp_fe_instr_realigner #(
   parameter int vaddr_width_p  = 39,
   parameter int instr_width_p  = 32,
   parameter int parcel_width_p = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     redirect_i,
   input  logic                     fetch_v_i,
   output logic                     fetch_ready_and_o,
   input  logic [vaddr_width_p-1:0] fetch_pc_i,
   input  logic [instr_width_p-1:0] fetch_data_i,
   output logic                     instr_v_o,
   input  logic                     instr_ready_and_i,
   output logic [instr_width_p-1:0] instr_o,
   output logic [vaddr_width_p-1:0] instr_pc_o,
   output logic                     instr_compressed_o
);
   localparam int pw = parcel_width_p;
   localparam logic [instr_width_p-pw-1:0] zext = '0;
   logic                     r_v, r_v_n;
   logic [pw-1:0]            r_parcel, r_parcel_n;
   logic [vaddr_width_p-1:0] r_pc, r_pc_n;
   logic                     v_n, c_n;
   logic [instr_width_p-1:0] i_n;
   logic [vaddr_width_p-1:0] pc_n;
   logic [pw-1:0]            p0, p1;
   logic [vaddr_width_p-1:0] pc_base;
   logic                     adv, acc, r_c, p0_c, p1_c;
   assign p0      = fetch_data_i[pw-1:0];
   assign p1      = fetch_data_i[2*pw-1:pw];
   assign pc_base = {fetch_pc_i[vaddr_width_p-1:2], 2'b00};
   assign r_c     = r_parcel[1:0] != 2'b11;
   assign p0_c    = p0[1:0] != 2'b11;
   assign p1_c    = p1[1:0] != 2'b11;
   assign adv     = !instr_v_o | instr_ready_and_i;
   // A compressed residual is emitted on its own, so no packet can be taken that cycle
   assign fetch_ready_and_o = adv & !redirect_i & !(r_v & r_c);
   assign acc = fetch_v_i & fetch_ready_and_o;
   always_comb begin
      r_v_n      = r_v;
      r_parcel_n = r_parcel;
      r_pc_n     = r_pc;
      v_n        = 1'b0;
      i_n        = instr_o;
      pc_n       = instr_pc_o;
      c_n        = instr_compressed_o;
      if (r_v && r_c) begin
         v_n   = 1'b1;
         i_n   = {zext, r_parcel};
         pc_n  = r_pc;
         c_n   = 1'b1;
         r_v_n = 1'b0;
      end else if (r_v && acc) begin
         // Residual is the low half of a straddling instruction; p1 becomes the new residual
         v_n        = 1'b1;
         i_n        = {p0, r_parcel};
         pc_n       = r_pc;
         c_n        = 1'b0;
         r_parcel_n = p1;
         r_pc_n     = pc_base + vaddr_width_p'(2);
      end else if (!r_v && acc && !fetch_pc_i[1]) begin
         v_n  = 1'b1;
         pc_n = fetch_pc_i;
         c_n  = p0_c;
         i_n  = p0_c ? {zext, p0} : fetch_data_i;
         if (p0_c) begin
            r_v_n      = 1'b1;
            r_parcel_n = p1;
            r_pc_n     = fetch_pc_i + vaddr_width_p'(2);
         end
      end else if (!r_v && acc) begin
         v_n  = p1_c;
         i_n  = {zext, p1};
         pc_n = fetch_pc_i;
         c_n  = 1'b1;
         if (!p1_c) begin
            r_v_n      = 1'b1;
            r_parcel_n = p1;
            r_pc_n     = fetch_pc_i;
         end
      end
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_v                <= 1'b0;
         r_parcel           <= '0;
         r_pc               <= '0;
         instr_v_o          <= 1'b0;
         instr_o            <= '0;
         instr_pc_o         <= '0;
         instr_compressed_o <= 1'b0;
      end else if (redirect_i) begin
         r_v       <= 1'b0;
         instr_v_o <= 1'b0;
      end else if (adv) begin
         r_v                <= r_v_n;
         r_parcel           <= r_parcel_n;
         r_pc               <= r_pc_n;
         instr_v_o          <= v_n;
         instr_o            <= i_n;
         instr_pc_o         <= pc_n;
         instr_compressed_o <= c_n;
      end
   end
endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// tb_bp_fe_instr_realigner: directed scoreboard bench for bp_fe_instr_realigner.
module tb_bp_fe_instr_realigner;
   typedef struct packed {
      logic [31:0] i;
      logic [38:0] pc;
      logic        c;
   } exp_t;
   logic        clk_i = 1'b0;
   logic        reset_i, redirect_i, fetch_v_i, fetch_ready_and_o;
   logic [38:0] fetch_pc_i, instr_pc_o;
   logic [31:0] fetch_data_i, instr_o;
   logic        instr_v_o, instr_ready_and_i, instr_compressed_o;
   exp_t        q[$];
   int          total = 0;
   int          passed = 0;
   logic        accepted;
   bp_fe_instr_realigner dut (
      .clk_i(clk_i), .reset_i(reset_i), .redirect_i(redirect_i),
      .fetch_v_i(fetch_v_i), .fetch_ready_and_o(fetch_ready_and_o),
      .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
      .instr_v_o(instr_v_o), .instr_ready_and_i(instr_ready_and_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_compressed_o(instr_compressed_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic push(input logic [31:0] i, input logic [38:0] pc, input logic c);
      exp_t e;
      e.i = i; e.pc = pc; e.c = c;
      q.push_back(e);
   endtask
   // One clock: score any output handshake and note fetch acceptance at the negedge,
   // then return just after the next posedge.
   task automatic tick();
      exp_t e;
      @(negedge clk_i);
      if (instr_v_o && instr_ready_and_i) begin
         chk("sb_nonempty", 80'(q.size() != 0), 80'(1));
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("instr", {instr_o, instr_pc_o, instr_compressed_o}, 80'(e));
         end
      end
      accepted = fetch_v_i & fetch_ready_and_o;
      @(posedge clk_i);
      #1;
   endtask
   task automatic send(input logic [38:0] pc, input logic [31:0] d);
      int n;
      fetch_pc_i = pc; fetch_data_i = d; fetch_v_i = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!accepted && n < 20);
      chk("send_accept", 80'(accepted), 80'(1));
      fetch_v_i = 1'b0;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || instr_v_o) && n < 20) begin tick(); n++; end
      chk("drain_q", 80'(q.size()), 80'(0));
      chk("drain_v", 80'(instr_v_o), 80'(0));
   endtask
   initial begin
      reset_i = 1'b1; redirect_i = 1'b0; fetch_v_i = 1'b0;
      fetch_pc_i = '0; fetch_data_i = '0; instr_ready_and_i = 1'b1;
      #1;
      chk("rst_v", 80'(instr_v_o), 80'(0));
      chk("rst_out", {instr_o, instr_pc_o, instr_compressed_o}, 80'(0));
      #12 reset_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_ready", 80'(fetch_ready_and_o), 80'(1));
      // aligned 32-bit
      push(32'h00A00093, 39'h1000, 1'b0);
      send(39'h1000, 32'h00A00093);
      chk("lat_aligned", 80'(instr_v_o), 80'(1));
      drain();
      chk("aligned_ready", 80'(fetch_ready_and_o), 80'(1));
      // two compressed parcels
      push(32'h00000001, 39'h2000, 1'b1);
      push(32'h00004505, 39'h2002, 1'b1);
      send(39'h2000, 32'h45050001);
      chk("cc_ready0", 80'(fetch_ready_and_o), 80'(0));
      tick();
      chk("cc_ready1", 80'(fetch_ready_and_o), 80'(1));
      drain();
      // straddling 32-bit instruction
      push(32'h00A00093, 39'h3002, 1'b0);
      push(32'h00004505, 39'h3006, 1'b1);
      send(39'h3002, 32'h00930000);
      chk("straddle_noemit", 80'(instr_v_o), 80'(0));
      send(39'h3004, 32'h450500A0);
      chk("straddle_emit", 80'(instr_v_o), 80'(1));
      drain();
      // backpressure
      push(32'h00000001, 39'h6000, 1'b1);
      push(32'h00004505, 39'h6002, 1'b1);
      push(32'h00A00093, 39'h6004, 1'b0);
      instr_ready_and_i = 1'b0;
      send(39'h6000, 32'h45050001);
      fetch_pc_i = 39'h6004; fetch_data_i = 32'h00A00093; fetch_v_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold", {instr_v_o, instr_o, instr_pc_o}, {1'b1, 32'h00000001, 39'h6000});
         chk("bp_ready", 80'(fetch_ready_and_o), 80'(0));
         chk("bp_noacc", 80'(accepted), 80'(0));
      end
      instr_ready_and_i = 1'b1;
      send(39'h6004, 32'h00A00093);
      drain();
      // redirect drops a captured straddle half
      send(39'h3002, 32'h00930000);
      redirect_i = 1'b1; fetch_v_i = 1'b1; fetch_pc_i = 39'h4000; fetch_data_i = 32'h00A00093;
      #1;
      chk("redir_ready", 80'(fetch_ready_and_o), 80'(0));
      tick();
      chk("redir_noacc", 80'(accepted), 80'(0));
      redirect_i = 1'b0; fetch_v_i = 1'b0;
      push(32'h00A00093, 39'h4000, 1'b0);
      send(39'h4000, 32'h00A00093);
      drain();
      // redirect drops an output held under backpressure
      instr_ready_and_i = 1'b0;
      send(39'h4100, 32'h00A00093);
      chk("held_v", 80'(instr_v_o), 80'(1));
      redirect_i = 1'b1;
      tick();
      redirect_i = 1'b0;
      chk("held_dropped", 80'(instr_v_o), 80'(0));
      instr_ready_and_i = 1'b1;
      push(32'h00B00113, 39'h4200, 1'b0);
      send(39'h4200, 32'h00B00113);
      drain();
      // upper-parcel start after redirect, compressed
      push(32'h00004505, 39'h4302, 1'b1);
      send(39'h4302, 32'h45050001);
      drain();
      // high address region
      push(32'h00000001, 39'h7FFFFFFFFC, 1'b1);
      push(32'h00004505, 39'h7FFFFFFFFE, 1'b1);
      send(39'h7FFFFFFFFC, 32'h45050001);
      drain();
      // async reset with residual valid and output held
      instr_ready_and_i = 1'b0;
      send(39'h2000, 32'h45050001);
      chk("prerst_v", 80'(instr_v_o), 80'(1));
      #2 reset_i = 1'b1;
      #1;
      chk("arst_v", 80'(instr_v_o), 80'(0));
      chk("arst_out", {instr_o, instr_pc_o, instr_compressed_o}, 80'(0));
      @(posedge clk_i); #3 reset_i = 1'b0;
      instr_ready_and_i = 1'b1;
      #1;
      chk("arst_ready", 80'(fetch_ready_and_o), 80'(1));
      push(32'h00A00093, 39'h5000, 1'b0);
      send(39'h5000, 32'h00A00093);
      drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
